// File: rtl/mips_trace_pkg.sv
// Shared definitions for the MipsCPU28 retirement trace buffer.
// Contents:
//   OVF_STOP / OVF_WRAP  overflow-mode selectors for the OVF_MODE parameter
//   TRACE_ENTRY_W        width of one trace entry {syscall, show, pc, data}
//   DATA_LSB, pc_lsb, show_bit, syscall_bit  field offsets inside an entry
package mips_trace_pkg;

  localparam int OVF_STOP = 0;
  localparam int OVF_WRAP = 1;

  localparam int DATA_LSB = 0;

  function automatic int TRACE_ENTRY_W(input int pc_w, input int data_w);
    return 2 + pc_w + data_w;
  endfunction

  function automatic int pc_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int show_bit(input int pc_w, input int data_w);
    return data_w + pc_w;
  endfunction

  function automatic int syscall_bit(input int pc_w, input int data_w);
    return data_w + pc_w + 1;
  endfunction

endpackage

// File: rtl/pipeline_trace_buffer_if.sv
// Capture/drain bus of the retirement trace buffer.
//   wb_valid, wb_pc, wb_data, wb_syscall, wb_show : retiring instruction from WB
//   rd_req                                         : pop request
//   rd_valid, rd_entry                             : popped entry (registered)
// master = CPU/drain side, slave = trace buffer.
interface pipeline_trace_buffer_if #(
  parameter int PC_W   = 12,
  parameter int DATA_W = 32
);
  import mips_trace_pkg::*;

  logic                                    wb_valid;
  logic [PC_W-1:0]                         wb_pc;
  logic [DATA_W-1:0]                       wb_data;
  logic                                    wb_syscall;
  logic                                    wb_show;
  logic                                    rd_req;
  logic                                    rd_valid;
  logic [TRACE_ENTRY_W(PC_W, DATA_W)-1:0]  rd_entry;

  modport master (
    output wb_valid, wb_pc, wb_data, wb_syscall, wb_show, rd_req,
    input  rd_valid, rd_entry
  );

  modport slave (
    input  wb_valid, wb_pc, wb_data, wb_syscall, wb_show, rd_req,
    output rd_valid, rd_entry
  );

endinterface

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one synchronous write port, one synchronous
// registered read port (read-first when both ports hit the same address).
//   clk    clock
//   srst   synchronous clear of the read data register only
//   we, waddr, wdata  write port
//   re, raddr, rdata  read port; rdata updates the edge after re
module trace_ram #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 46,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (srst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Retirement trace FIFO for the 5-stage MipsCPU28 pipeline, with
// freeze-on-syscall, stop/wrap overflow handling and saturating
// cycle/retire/stall counters.
//   clk, CPU_RESETN  clock and synchronous active-low reset
//   bus              capture/drain interface (slave side)
//   pc_enable        pipeline advancing (0 = stall cycle)
//   freeze_en        freeze capture after a syscall retires
//   clear            same effect as reset
//   count, empty, full, frozen, overflow  FIFO status
//   cycle_cnt, retire_cnt, stall_cnt      saturating counters
module pipeline_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter  int PC_W     = 12,
  parameter  int DATA_W   = 32,
  parameter  int DEPTH    = 16,
  parameter  int CNT_W    = 32,
  parameter  int OVF_MODE = OVF_STOP,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   CPU_RESETN,
  pipeline_trace_buffer_if.slave bus,
  input  logic                   pc_enable,
  input  logic                   freeze_en,
  input  logic                   clear,
  output logic [CW-1:0]          count,
  output logic                   empty,
  output logic                   full,
  output logic                   frozen,
  output logic                   overflow,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       retire_cnt,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int ENTRY_W  = TRACE_ENTRY_W(PC_W, DATA_W);
  localparam int PC_LSB   = pc_lsb(DATA_W);
  localparam int SHOW_BIT = show_bit(PC_W, DATA_W);
  localparam int SYS_BIT  = syscall_bit(PC_W, DATA_W);

  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [ENTRY_W-1:0] entry, rd_data;
  logic               srst, capture, pop, wr_en, overwrite, lost;

  assign srst    = !CPU_RESETN || clear;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign capture = bus.wb_valid && !frozen;
  assign pop     = bus.rd_req && !empty;

  // A full FIFO still accepts a write when a pop frees a slot this cycle,
  // or in wrap mode where the oldest entry is sacrificed.
  assign wr_en     = capture && (!full || pop || (OVF_MODE == OVF_WRAP));
  assign overwrite = capture && full && !pop && (OVF_MODE == OVF_WRAP);
  assign lost      = capture && full && !pop;

  always_comb begin
    entry                       = '0;
    entry[DATA_LSB +: DATA_W]   = bus.wb_data;
    entry[PC_LSB +: PC_W]       = bus.wb_pc;
    entry[SHOW_BIT]             = bus.wb_show;
    entry[SYS_BIT]              = bus.wb_syscall;
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .srst  (srst),
    .we    (wr_en && !srst),
    .waddr (wr_ptr),
    .wdata (entry),
    .re    (pop),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign bus.rd_entry = rd_data;

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      frozen       <= 1'b0;
      overflow     <= 1'b0;
      bus.rd_valid <= 1'b0;
      cycle_cnt    <= '0;
      retire_cnt   <= '0;
      stall_cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop || overwrite) rd_ptr <= rd_ptr + AW'(1);

      // Write+pop and overwrite both leave the occupancy unchanged.
      if (wr_en && !pop && !overwrite) count <= count + CW'(1);
      else if (pop && !wr_en)          count <= count - CW'(1);

      if (lost) overflow <= 1'b1;
      if (freeze_en && capture && bus.wb_syscall) frozen <= 1'b1;

      bus.rd_valid <= pop;

      if (cycle_cnt != '1)                 cycle_cnt  <= cycle_cnt + CNT_W'(1);
      if (bus.wb_valid && retire_cnt != '1) retire_cnt <= retire_cnt + CNT_W'(1);
      if (!pc_enable && stall_cnt != '1)   stall_cnt  <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Directed bench for pipeline_trace_buffer. Two DEPTH=4 instances share all
// inputs: one in stop mode with 32-bit counters, one in wrap mode with
// 4-bit counters so saturation is reachable.
module tb_pipeline_trace_buffer;
  import mips_trace_pkg::*;

  localparam int PC_W = 12;
  localparam int DATA_W = 32;
  localparam int EW = 2 + PC_W + DATA_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn, pc_enable, freeze_en, clear;
  logic              wb_valid, wb_syscall, wb_show, rd_req;
  logic [PC_W-1:0]   wb_pc;
  logic [DATA_W-1:0] wb_data;

  pipeline_trace_buffer_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus_s ();
  pipeline_trace_buffer_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus_w ();

  assign bus_s.wb_valid = wb_valid;   assign bus_w.wb_valid = wb_valid;
  assign bus_s.wb_pc = wb_pc;         assign bus_w.wb_pc = wb_pc;
  assign bus_s.wb_data = wb_data;     assign bus_w.wb_data = wb_data;
  assign bus_s.wb_syscall = wb_syscall; assign bus_w.wb_syscall = wb_syscall;
  assign bus_s.wb_show = wb_show;     assign bus_w.wb_show = wb_show;
  assign bus_s.rd_req = rd_req;       assign bus_w.rd_req = rd_req;

  logic [2:0]  count_s, count_w;
  logic        empty_s, empty_w, full_s, full_w, frozen_s, frozen_w, ovf_s, ovf_w;
  logic [31:0] cyc_s, ret_s, stl_s;
  logic [3:0]  cyc_w, ret_w, stl_w;

  pipeline_trace_buffer #(
    .PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(4), .CNT_W(32), .OVF_MODE(OVF_STOP)
  ) dut_stop (
    .clk(clk), .CPU_RESETN(rstn), .bus(bus_s), .pc_enable(pc_enable),
    .freeze_en(freeze_en), .clear(clear), .count(count_s), .empty(empty_s),
    .full(full_s), .frozen(frozen_s), .overflow(ovf_s), .cycle_cnt(cyc_s),
    .retire_cnt(ret_s), .stall_cnt(stl_s)
  );

  pipeline_trace_buffer #(
    .PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(4), .CNT_W(4), .OVF_MODE(OVF_WRAP)
  ) dut_wrap (
    .clk(clk), .CPU_RESETN(rstn), .bus(bus_w), .pc_enable(pc_enable),
    .freeze_en(freeze_en), .clear(clear), .count(count_w), .empty(empty_w),
    .full(full_w), .frozen(frozen_w), .overflow(ovf_w), .cycle_cnt(cyc_w),
    .retire_cnt(ret_w), .stall_cnt(stl_w)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [EW-1:0] ent(input logic sys, input logic [PC_W-1:0] pc,
                                        input logic [DATA_W-1:0] data);
    return {sys, 1'b0, pc, data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; pc_enable = 1'b1; freeze_en = 1'b0; clear = 1'b0;
    wb_valid = 1'b0; wb_syscall = 1'b0; wb_show = 1'b0; rd_req = 1'b0;
    wb_pc = '0; wb_data = '0;

    // Reset state
    tick(); tick();
    check("rst_count", count_s, 0);
    check("rst_empty", empty_s, 1);
    check("rst_full", full_s, 0);
    check("rst_rd_valid", bus_s.rd_valid, 0);
    check("rst_cycle", cyc_s, 0);
    check("rst_ovf_frz", {ovf_s, frozen_s}, 0);
    rstn = 1'b1;

    // 1: three retires, three pops, in order with one-cycle latency
    wb_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb_pc = PC_W'(4 * i); wb_data = DATA_W'(i + 1);
      tick();
    end
    wb_valid = 1'b0;
    check("t1_count3", count_s, 3);
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_rd_valid", bus_s.rd_valid, 1);
      check("t1_entry", bus_s.rd_entry, ent(1'b0, PC_W'(4 * i), DATA_W'(i + 1)));
      check("t1_count", count_s, 3'(2 - i));
    end
    rd_req = 1'b0;
    check("t1_empty", empty_s, 1);
    tick();
    check("t1_rd_valid_low", bus_s.rd_valid, 0);

    // 2/3: six retires into a 4-deep FIFO, stop vs wrap
    wb_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wb_pc = PC_W'(12'h10 + 4 * i); wb_data = DATA_W'(32'h100 + i);
      tick();
    end
    wb_valid = 1'b0;
    check("t2_count", count_s, 4);
    check("t2_full", full_s, 1);
    check("t2_ovf", ovf_s, 1);
    check("t3_count", count_w, 4);
    check("t3_ovf", ovf_w, 1);
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_pop", bus_s.rd_entry, ent(1'b0, PC_W'(12'h10 + 4 * i), DATA_W'(32'h100 + i)));
      check("t3_pop", bus_w.rd_entry, ent(1'b0, PC_W'(12'h18 + 4 * i), DATA_W'(32'h102 + i)));
    end
    rd_req = 1'b0;
    check("t23_empty", {empty_s, empty_w}, 2'b11);

    // 5: capture + pop while full, then pop on empty
    pulse_clear();
    check("t5_clr_ovf", {ovf_s, ovf_w}, 0);
    wb_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb_pc = PC_W'(12'h50 + 4 * i); wb_data = DATA_W'(32'h500 + i);
      tick();
    end
    wb_pc = 12'h060; wb_data = 32'h504; rd_req = 1'b1;
    tick();
    wb_valid = 1'b0;
    check("t5_count_s", count_s, 4);
    check("t5_count_w", count_w, 4);
    check("t5_oldest_s", bus_s.rd_entry, ent(1'b0, 12'h050, 32'h500));
    check("t5_oldest_w", bus_w.rd_entry, ent(1'b0, 12'h050, 32'h500));
    check("t5_no_ovf", {ovf_s, ovf_w}, 0);
    for (int i = 1; i < 5; i++) begin
      tick();
      check("t5_drain_s", bus_s.rd_entry, ent(1'b0, PC_W'(12'h50 + 4 * i), DATA_W'(32'h500 + i)));
      check("t5_drain_w", bus_w.rd_entry, ent(1'b0, PC_W'(12'h50 + 4 * i), DATA_W'(32'h500 + i)));
    end
    tick();
    rd_req = 1'b0;
    check("t5_pop_empty_valid", bus_s.rd_valid, 0);
    check("t5_pop_empty_count", count_s, 0);

    // 4: freeze on syscall
    pulse_clear();
    freeze_en = 1'b1; wb_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb_pc = PC_W'(12'h40 + 4 * i); wb_data = DATA_W'(32'h400 + i);
      wb_syscall = (i == 1);
      tick();
    end
    wb_valid = 1'b0; wb_syscall = 1'b0;
    check("t4_frozen", frozen_s, 1);
    check("t4_count", count_s, 2);
    check("t4_retire", ret_s, 4);
    rd_req = 1'b1;
    tick(); tick();
    rd_req = 1'b0;
    check("t4_sys_entry", bus_s.rd_entry, ent(1'b1, 12'h044, 32'h401));
    check("t4_still_frozen", frozen_s, 1);
    pulse_clear();
    freeze_en = 1'b0;
    check("t4_clr_count", count_s, 0);
    check("t4_clr_frozen", frozen_s, 0);
    check("t4_clr_cnts", {cyc_s, ret_s, stl_s}, 0);

    // 6: stall and cycle counters, saturation on 4-bit counters
    for (int i = 0; i < 20; i++) begin
      pc_enable = !(i == 2 || i == 3 || i == 4 || i == 9 || i == 10 || i == 15 || i == 19);
      tick();
    end
    pc_enable = 1'b1;
    check("t6_cycle", cyc_s, 20);
    check("t6_stall", stl_s, 7);
    check("t6_cycle_sat", cyc_w, 15);
    check("t6_stall_w", stl_w, 7);

    // Reset mid-burst overrides capture and pop
    wb_valid = 1'b1;
    wb_pc = 12'h070; tick();
    wb_pc = 12'h074; tick();
    wb_pc = 12'h078; rd_req = 1'b1; tick();
    check("t6_pre_rd_valid", bus_s.rd_valid, 1);
    rstn = 1'b0; wb_pc = 12'h07C;
    tick();
    check("t6_rst_count", count_s, 0);
    check("t6_rst_empty", empty_s, 1);
    check("t6_rst_rd", {bus_s.rd_valid, bus_s.rd_entry}, 0);
    check("t6_rst_cnts", {cyc_s, ret_s, stl_s}, 0);
    check("t6_rst_w", {count_w, cyc_w, ret_w, ovf_w}, 0);
    wb_valid = 1'b0; rd_req = 1'b0; rstn = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
